// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int TICK_CNT_W = 6;
  localparam int BIT_CNT_W  = 4;

  // data_xor is the reduction XOR of the received data bits.
  function automatic logic parity_ok(input logic data_xor, input logic par_bit, input int mode);
    return (mode == PAR_ODD) ? (data_xor ^ par_bit) : ~(data_xor ^ par_bit);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Oversample tick counter and frame bit counter; flags the mid-bit sample points.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic restart,
  input  logic half_period,
  output logic sample_now,
  output logic last_data,
  output logic last_frame
);

  localparam int FRAME_BITS = DATA_BITS + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;
  localparam logic [TICK_CNT_W-1:0] HALF_LAST  = TICK_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_CNT_W-1:0] FULL_LAST  = TICK_CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0]  DATA_LAST  = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0]  FRAME_LAST = BIT_CNT_W'(FRAME_BITS - 1);

  logic [TICK_CNT_W-1:0] tick_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  assign sample_now = sample_en && !restart &&
                      (tick_cnt == (half_period ? HALF_LAST : FULL_LAST));
  assign last_data  = (bit_cnt == DATA_LAST);
  assign last_frame = (bit_cnt == FRAME_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (restart || sample_now) begin
      tick_cnt <= '0;
    end else if (sample_en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Bit index runs across data, parity and stop bits; the start bit is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (restart) begin
      bit_cnt <= '0;
    end else if (sample_now && !half_period) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_core.sv
// Oversampling asynchronous serial receiver with a held valid/ready output stage.
module serial_rx_core
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic                 data_in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  rx_state_t            state;
  logic                 sync_meta;
  logic                 line;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 sample_now;
  logic                 last_data;
  logic                 last_frame;
  logic                 done;
  logic                 handshake;
  logic                 parity_bad;
  logic                 frame_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      line      <= 1'b1;
    end else begin
      sync_meta <= data_in;
      line      <= sync_meta;
    end
  end

  serial_bit_timer #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .restart     (state == IDLE),
    .half_period (state == START),
    .sample_now  (sample_now),
    .last_data   (last_data),
    .last_frame  (last_frame)
  );

  assign done       = (state == STOP) && sample_now && last_frame;
  assign handshake  = valid && ready;
  assign frame_bad  = stop_err | ~line;
  assign parity_bad = (PARITY == PAR_NONE) ? 1'b0 : ~parity_ok(^shift_reg, par_bit, PARITY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_en && !line) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (sample_now) begin
            par_bit  <= 1'b0;
            stop_err <= 1'b0;
            if (line) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
            if (last_data) state <= (PARITY == PAR_NONE) ? STOP : PAR;
          end
        end
        PAR: begin
          if (sample_now) begin
            par_bit <= line;
            state   <= STOP;
          end
        end
        STOP: begin
          if (sample_now) begin
            stop_err <= frame_bad;
            if (last_frame) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A finished character is dropped only when the held one is not being taken this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && valid && !ready) begin
      overrun <= 1'b1;
    end else begin
      if (done) begin
        data_out   <= shift_reg;
        valid      <= 1'b1;
        parity_err <= parity_bad;
        frame_err  <= frame_bad;
      end else if (handshake) begin
        valid <= 1'b0;
      end
      if (handshake) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_rx_core.sv
// Randomised bench for serial_rx_core: an 8N1 instance and an 8E2 instance against a frame-level model.
module tb_serial_rx_core;
  import serial_pkg::*;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_en = 1'b0;
  logic       line_n, line_e, ready_n, ready_e;
  logic [7:0] dout_n, dout_e;
  logic       valid_n, perr_n, ferr_n, ovr_n, busy_n;
  logic       valid_e, perr_e, ferr_e, ovr_e, busy_e;

  int          n_checks = 0;
  int          n_pass = 0;
  int          vcyc_n = 0;
  bit          busy_seen_n = 1'b0;
  logic [31:0] got_n[$];
  logic [31:0] got_e[$];
  logic [31:0] exp_n[$];
  logic [31:0] exp_e[$];

  serial_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_NONE), .STOP_BITS(1)) u_n (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .data_in(line_n), .ready(ready_n),
    .data_out(dout_n), .valid(valid_n), .parity_err(perr_n), .frame_err(ferr_n),
    .overrun(ovr_n), .busy(busy_n));

  serial_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_e (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .data_in(line_e), .ready(ready_e),
    .data_out(dout_e), .valid(valid_e), .parity_err(perr_e), .frame_err(ferr_e),
    .overrun(ovr_e), .busy(busy_e));

  always #5 clk = ~clk;

  // Irregular tick spacing so counters must advance only on sample_en.
  always @(negedge clk) sample_en = ($urandom_range(0, 2) != 0);

  always @(negedge clk) begin
    if (valid_n) vcyc_n++;
    if (busy_n) busy_seen_n = 1'b1;
    if (valid_n && ready_n) got_n.push_back({22'b0, ferr_n, perr_n, dout_n});
    if (valid_e && ready_e) got_e.push_back({22'b0, ferr_e, perr_e, dout_e});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Reference character: {frame_err, parity_err, data} from what was put on the line.
  function automatic logic [31:0] expect_char(input logic [7:0] data, input int mode, input logic pbit,
                                              input logic [1:0] stops, input int nstops);
    int   ones;
    logic perr;
    logic ferr;
    ones = $countones(data) + int'(pbit);
    perr = 1'b0;
    if (mode == PAR_EVEN) perr = (ones % 2) != 0;
    if (mode == PAR_ODD)  perr = (ones % 2) != 1;
    ferr = (stops[0] == 1'b0) || (nstops == 2 && stops[1] == 1'b0);
    return {22'b0, ferr, perr, data};
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!sample_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input int which, input logic v);
    if (which == 0) line_n = v;
    else line_e = v;
    wait_ticks(OS);
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] data, input bit has_par, input logic pbit,
                               input logic [1:0] stops, input int nstops, input int gap);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, data[i]);
    if (has_par) send_bit(which, pbit);
    for (int s = 0; s < nstops; s++) send_bit(which, stops[s]);
    if (which == 0) line_n = 1'b1;
    else line_e = 1'b1;
    wait_ticks(gap);
  endtask

  function automatic logic [31:0] pop_n();
    return (got_n.size() > 0) ? got_n.pop_front() : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] pop_e();
    return (got_e.size() > 0) ? got_e.pop_front() : 32'hDEADBEEF;
  endfunction

  initial begin
    logic [7:0]  d;
    logic [1:0]  st;
    logic        pb;
    int          gap;
    reset_n = 1'b0;
    line_n  = 1'b1;
    line_e  = 1'b1;
    ready_n = 1'b1;
    ready_e = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_outputs_n", {18'b0, ovr_n, busy_n, valid_n, perr_n, ferr_n, 1'b0, dout_n}, 32'h0);
    checkOutput("reset_outputs_e", {18'b0, ovr_e, busy_e, valid_e, perr_e, ferr_e, 1'b0, dout_e}, 32'h0);
    reset_n = 1'b1;
    wait_ticks(5);
    checkOutput("idle_after_reset", {29'b0, busy_n, valid_n, ovr_n}, 32'h0);

    // 8N1 0xA5 with ready high
    vcyc_n = 0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, 4);
    checkOutput("a5_count", got_n.size(), 1);
    checkOutput("a5_char", pop_n(), {22'b0, 1'b0, 1'b0, 8'hA5});
    checkOutput("a5_valid_cycles", vcyc_n, 1);
    checkOutput("a5_busy_after", {31'b0, busy_n}, 0);

    // short low glitch is a false start
    vcyc_n = 0;
    busy_seen_n = 1'b0;
    line_n = 1'b0;
    wait_ticks(6);
    line_n = 1'b1;
    wait_ticks(30);
    checkOutput("glitch_busy_seen", {31'b0, busy_seen_n}, 1);
    checkOutput("glitch_busy_fell", {31'b0, busy_n}, 0);
    checkOutput("glitch_no_valid", vcyc_n, 0);

    // even parity, 0x03 with parity bit 1
    applyStimulus(1, 8'h03, 1'b1, 1'b1, 2'b11, 2, 4);
    checkOutput("par03_count", got_e.size(), 1);
    checkOutput("par03_char", pop_e(), {22'b0, 1'b0, 1'b1, 8'h03});

    // stop bit low, then a clean frame
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 2'b10, 1, 24);
    applyStimulus(0, 8'h0F, 1'b0, 1'b0, 2'b11, 1, 4);
    checkOutput("ferr_count", got_n.size(), 2);
    checkOutput("ferr55_char", pop_n(), {22'b0, 1'b1, 1'b0, 8'h55});
    checkOutput("clean0f_char", pop_n(), {22'b0, 1'b0, 1'b0, 8'h0F});

    // overrun with ready held low
    ready_n = 1'b0;
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 2'b11, 1, 2);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 2'b11, 1, 4);
    checkOutput("ovr_held_data", {24'b0, dout_n}, 32'h11);
    checkOutput("ovr_flags", {29'b0, valid_n, ovr_n, ferr_n}, 32'h6);
    @(posedge clk);
    #1 ready_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ovr_cleared", {30'b0, valid_n, ovr_n}, 0);
    checkOutput("ovr_taken", pop_n(), {22'b0, 1'b0, 1'b0, 8'h11});
    checkOutput("ovr_dropped", got_n.size(), 0);

    // reset in the middle of a frame
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'(i % 2));
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_busy", {30'b0, busy_n, valid_n}, 0);
    line_n  = 1'b1;
    reset_n = 1'b1;
    wait_ticks(20);
    applyStimulus(0, 8'h7E, 1'b0, 1'b0, 2'b11, 1, 4);
    checkOutput("midrst_count", got_n.size(), 1);
    checkOutput("midrst_char", pop_n(), {22'b0, 1'b0, 1'b0, 8'h7E});

    // randomised frames, 8N1
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      st  = {1'b1, ($urandom_range(0, 3) != 0)};
      gap = (st[0] == 1'b0) ? 20 + $urandom_range(0, 5) : $urandom_range(0, 6);
      exp_n.push_back(expect_char(d, PAR_NONE, 1'b0, st, 1));
      applyStimulus(0, d, 1'b0, 1'b0, st, 1, gap);
    end
    wait_ticks(4);
    checkOutput("rand_n_count", got_n.size(), exp_n.size());
    while (exp_n.size() > 0) checkOutput("rand_n_char", pop_n(), exp_n.pop_front());

    // randomised frames, 8E2
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      pb  = 1'($urandom_range(0, 1));
      st  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      gap = (st[1] == 1'b0) ? 20 + $urandom_range(0, 5) : $urandom_range(0, 6);
      exp_e.push_back(expect_char(d, PAR_EVEN, pb, st, 2));
      applyStimulus(1, d, 1'b1, pb, st, 2, gap);
    end
    wait_ticks(4);
    checkOutput("rand_e_count", got_e.size(), exp_e.size());
    while (exp_e.size() > 0) checkOutput("rand_e_char", pop_e(), exp_e.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
